dit4_merge_ctrl: RTL and testbench
==================================

// Module: dit4_merge_ctrl
// PURPOSE
//  Sequencer for one radix-4 DIT merge stage: steps butterfly index k over 0..M-1 (M = N/4).
//  Issues, per cycle:
//   - the sample read index (the four operands are k, k+M, k+2M, k+3M);
//   - twiddle addresses for branches 1..3 (branch 0 takes the X0 shift path, no twiddle).
//  Tracks validity through the fixed-latency butterfly datapath and emits aligned write
//  strobes and indices. Sits between the stage sample memories / twiddle ROM and the
//  X0-shift / twiddle-multiply / adder datapath.
// PARAMETERS
//  N_LOG2    10  log2 of FFT length N; M = 2**(N_LOG2-2); N_LOG2 >= 3
//  PIPE_LAT  2   datapath latency in cycles from rd_en to result valid; >= 1
// PORTS
//  clk        in   1           clock, rising edge
//  rst_n      in   1           asynchronous active-low reset
//  start      in   1           pulse: begin one merge pass; honoured only in IDLE
//  hold       in   1           1 = suppress issue this cycle (memory port busy)
//  rd_en      out  1           operand read strobe for index rd_k
//  rd_k       out  N_LOG2-2    butterfly index k (operand addresses k + p*M, p=0..3)
//  tw_addr1   out  N_LOG2      twiddle ROM address for branch 1 = k       mod N
//  tw_addr2   out  N_LOG2      twiddle ROM address for branch 2 = 2k      mod N
//  tw_addr3   out  N_LOG2      twiddle ROM address for branch 3 = 3k      mod N
//  wr_en      out  1           result write strobe; rd_en delayed PIPE_LAT cycles
//  wr_k       out  N_LOG2-2    result index; rd_k delayed PIPE_LAT cycles
//  busy       out  1           1 in RUN or DRAIN
//  done       out  1           single-cycle pulse when the pass completes
// BEHAVIOUR
//  Reset: all outputs 0; k=0; FSM=IDLE; valid/index delay lines cleared. Reset is async;
//   asserting it mid-pass aborts the pass immediately (no done; in-flight writes dropped).
//  FSM IDLE -> RUN on start.
//   RUN: each cycle with hold=0 -> rd_en=1, rd_k=k, tw_addr*=p*k, k++;
//        hold=1 -> rd_en=0, k frozen.
//   RUN -> DRAIN in the cycle k=M-1 is issued.
//  DRAIN: no issue; counts PIPE_LAT cycles.
//   -> DONE after the final wr_en has been presented.
//  DONE: done=1 for one cycle, busy=0 -> IDLE.
//  rd_en, rd_k and tw_addr* are registered outputs (same cycle as the issue decision).
//   tw_addr* are combinational products of k, registered once, widths truncated mod N.
//   2k and 3k are computed with shift/add (no multiplier); 3k < 3N/4 never wraps.
//  Delay lines: PIPE_LAT-deep shift registers for {rd_en, rd_k}.
//   wr_en/wr_k are their last stages.
//   Delay lines keep shifting during hold (holes propagate as wr_en=0).
//  start while busy or in DONE: ignored, no effect on k or outputs.
//  start in the same cycle as the done pulse: ignored; a new pass needs start in IDLE.
//  hold in IDLE/DRAIN/DONE: no effect.
//  Exactly M rd_en pulses and M wr_en pulses per pass.
//   wr_k sequence 0..M-1, strictly increasing.
//  done asserts exactly one cycle after the cycle carrying the last wr_en.
// TESTING  (N_LOG2=4, M=4, PIPE_LAT=2 unless noted)
//  1 reset, start pulse, hold=0 -> rd_en 4 cycles, rd_k 0,1,2,3;
//    tw_addr1 0,1,2,3; tw_addr2 0,2,4,6; tw_addr3 0,3,6,9;
//    wr_k 0..3 two cycles later; done one cycle after wr_k=3; busy low with done.
//  2 hold=1 for 2 cycles after k=1 issue -> rd_k 0,1,-,-,2,3; wr_en gaps aligned;
//    still 4 writes; done delayed by 2 cycles.
//  3 start re-pulsed during RUN and during DONE -> ignored;
//    exactly 4 rd_en / 4 wr_en; single done.
//  4 rst_n low after rd_k=2 issued -> all outputs 0 within the reset cycle;
//    no done; fresh start restarts at k=0.
//  5 N_LOG2=10, PIPE_LAT=5 -> 256 issues; tw_addr3 at k=255 = 765;
//    wr_en lags rd_en by exactly 5; busy=1 for 256+5 cycles.
//  6 back-to-back passes: start in IDLE cycle after done -> second pass identical to first.

Source files
------------

// File: rtl/dit4_merge_ctrl.sv
// Radix-4 DIT merge-stage sequencer: issues butterfly reads/twiddle addresses, delays write strobes.
// Latency: rd_* one cycle after the issue decision; wr_* trail rd_* by PIPE_LAT cycles; done one cycle after last wr_en.
// Backpressure: hold=1 freezes k and suppresses rd_en; delay line keeps shifting so holes appear as wr_en=0.
module dit4_merge_ctrl #(
  parameter int N_LOG2   = 10,
  parameter int PIPE_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              hold,
  output logic              rd_en,
  output logic [N_LOG2-3:0] rd_k,
  output logic [N_LOG2-1:0] tw_addr1,
  output logic [N_LOG2-1:0] tw_addr2,
  output logic [N_LOG2-1:0] tw_addr3,
  output logic              wr_en,
  output logic [N_LOG2-3:0] wr_k,
  output logic              busy,
  output logic              done
);

  localparam int KW = N_LOG2 - 2;
  localparam int CW = $clog2(PIPE_LAT + 1) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [CW-1:0]     drain_cnt_q, drain_cnt_d;
  logic              rd_en_q, rd_en_d;
  logic [KW-1:0]     rd_k_q, rd_k_d;
  logic [N_LOG2-1:0] tw1_q, tw1_d, tw2_q, tw2_d, tw3_q, tw3_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              en_dly_q [PIPE_LAT];
  logic              en_dly_d [PIPE_LAT];
  logic [KW-1:0]     k_dly_q  [PIPE_LAT];
  logic [KW-1:0]     k_dly_d  [PIPE_LAT];

  // Twiddle products by shift/add; 3k < 3N/4 so the sum never wraps.
  logic [N_LOG2-1:0] tw1_c, tw2_c, tw3_c;
  assign tw1_c = {2'b00, k_q};
  assign tw2_c = {1'b0, k_q, 1'b0};
  assign tw3_c = tw1_c + tw2_c;

  // Sequencer next-state: issue in RUN, count out the pipeline in DRAIN, pulse done from DONE.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    drain_cnt_d = drain_cnt_q;
    rd_en_d     = 1'b0;
    rd_k_d      = rd_k_q;
    tw1_d       = tw1_q;
    tw2_d       = tw2_q;
    tw3_d       = tw3_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d = RUN;
          k_d     = '0;
        end
      end
      RUN: begin
        busy_d = 1'b1;
        if (!hold) begin
          rd_en_d = 1'b1;
          rd_k_d  = k_q;
          tw1_d   = tw1_c;
          tw2_d   = tw2_c;
          tw3_d   = tw3_c;
          k_d     = k_q + 1'b1;
          if (&k_q) begin
            state_d     = DRAIN;
            drain_cnt_d = '0;
          end
        end
      end
      DRAIN: begin
        // The final rd_en reaches wr_en PIPE_LAT cycles after entering DRAIN.
        if (drain_cnt_q == CW'(PIPE_LAT)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          busy_d      = 1'b1;
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Delay line for {rd_en, rd_k}; shifts unconditionally so holds become write holes.
  always_comb begin
    en_dly_d[0] = rd_en_q;
    k_dly_d[0]  = rd_k_q;
    for (int i = 1; i < PIPE_LAT; i++) begin
      en_dly_d[i] = en_dly_q[i-1];
      k_dly_d[i]  = k_dly_q[i-1];
    end
  end

  // All state and registered outputs; async reset aborts any pass in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      drain_cnt_q <= '0;
      rd_en_q     <= 1'b0;
      rd_k_q      <= '0;
      tw1_q       <= '0;
      tw2_q       <= '0;
      tw3_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        en_dly_q[i] <= 1'b0;
        k_dly_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      drain_cnt_q <= drain_cnt_d;
      rd_en_q     <= rd_en_d;
      rd_k_q      <= rd_k_d;
      tw1_q       <= tw1_d;
      tw2_q       <= tw2_d;
      tw3_q       <= tw3_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      for (int i = 0; i < PIPE_LAT; i++) begin
        en_dly_q[i] <= en_dly_d[i];
        k_dly_q[i]  <= k_dly_d[i];
      end
    end
  end

  assign rd_en    = rd_en_q;
  assign rd_k     = rd_k_q;
  assign tw_addr1 = tw1_q;
  assign tw_addr2 = tw2_q;
  assign tw_addr3 = tw3_q;
  assign wr_en    = en_dly_q[PIPE_LAT-1];
  assign wr_k     = k_dly_q[PIPE_LAT-1];
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_dit4_merge_ctrl.sv
// Bench for dit4_merge_ctrl: small (N_LOG2=4, PIPE_LAT=2) and large (N_LOG2=10, PIPE_LAT=5) instances.
// Expected traces are built per pass from the hold pattern with plain cycle arithmetic.
// Inputs driven 1 time unit after posedge, outputs sampled on negedge.
module tb_dit4_merge_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic hold = 1'b0;
  int   sel = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  logic       a_start, a_hold, a_rd_en, a_wr_en, a_busy, a_done;
  logic [1:0] a_rd_k, a_wr_k;
  logic [3:0] a_tw1, a_tw2, a_tw3;
  logic       b_start, b_hold, b_rd_en, b_wr_en, b_busy, b_done;
  logic [7:0] b_rd_k, b_wr_k;
  logic [9:0] b_tw1, b_tw2, b_tw3;

  assign a_start = (sel == 0) ? start : 1'b0;
  assign a_hold  = (sel == 0) ? hold  : 1'b0;
  assign b_start = (sel == 1) ? start : 1'b0;
  assign b_hold  = (sel == 1) ? hold  : 1'b0;

  dit4_merge_ctrl #(.N_LOG2(4), .PIPE_LAT(2)) u_small (
    .clk(clk), .rst_n(rst_n), .start(a_start), .hold(a_hold),
    .rd_en(a_rd_en), .rd_k(a_rd_k), .tw_addr1(a_tw1), .tw_addr2(a_tw2), .tw_addr3(a_tw3),
    .wr_en(a_wr_en), .wr_k(a_wr_k), .busy(a_busy), .done(a_done)
  );

  dit4_merge_ctrl #(.N_LOG2(10), .PIPE_LAT(5)) u_large (
    .clk(clk), .rst_n(rst_n), .start(b_start), .hold(b_hold),
    .rd_en(b_rd_en), .rd_k(b_rd_k), .tw_addr1(b_tw1), .tw_addr2(b_tw2), .tw_addr3(b_tw3),
    .wr_en(b_wr_en), .wr_k(b_wr_k), .busy(b_busy), .done(b_done)
  );

  logic       o_rd_en, o_wr_en, o_busy, o_done;
  logic [9:0] o_rd_k, o_wr_k, o_tw1, o_tw2, o_tw3;

  always_comb begin
    if (sel == 1) begin
      o_rd_en = b_rd_en; o_rd_k = 10'(b_rd_k);
      o_tw1 = b_tw1; o_tw2 = b_tw2; o_tw3 = b_tw3;
      o_wr_en = b_wr_en; o_wr_k = 10'(b_wr_k);
      o_busy = b_busy; o_done = b_done;
    end else begin
      o_rd_en = a_rd_en; o_rd_k = 10'(a_rd_k);
      o_tw1 = 10'(a_tw1); o_tw2 = 10'(a_tw2); o_tw3 = 10'(a_tw3);
      o_wr_en = a_wr_en; o_wr_k = 10'(a_wr_k);
      o_busy = a_busy; o_done = a_done;
    end
  end

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({a_rd_en, a_rd_k, a_tw1, a_tw2, a_tw3, a_wr_en, a_wr_k, a_busy, a_done} !== '0) begin
      n_fail++;
      $display("FAIL reset_small outputs got %h required 0",
               {a_rd_en, a_rd_k, a_tw1, a_tw2, a_tw3, a_wr_en, a_wr_k, a_busy, a_done});
    end
    n_tests++;
    if ({b_rd_en, b_rd_k, b_tw1, b_tw2, b_tw3, b_wr_en, b_wr_k, b_busy, b_done} !== '0) begin
      n_fail++;
      $display("FAIL reset_large outputs got %h required 0",
               {b_rd_en, b_rd_k, b_tw1, b_tw2, b_tw3, b_wr_en, b_wr_k, b_busy, b_done});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One pass starting with start in cycle 0. hold_mode: 0 none, 1 random, 2 two holds after k=1.
  // spam re-pulses start during the pass including the done cycle. tail = idle cycles after done.
  task automatic run_pass(input int which, input int hold_mode, input bit spam, input int tail);
    int m, pl, n, k, c, last_rd, d, endc, rd_cnt, wr_cnt, done_cnt;
    bit hv [1024];
    bit e_rd [1024];
    bit e_wr [1024];
    bit e_busy [1024];
    bit e_done [1024];
    int e_rk [1024];
    int e_wk [1024];
    m  = (which == 1) ? 256 : 4;
    pl = (which == 1) ? 5 : 2;
    n  = 4 * m;
    for (int i = 0; i < 1024; i++) begin
      e_rd[i] = 0; e_wr[i] = 0; e_busy[i] = 0; e_done[i] = 0; e_rk[i] = 0; e_wk[i] = 0;
      hv[i] = (hold_mode == 1 && i < 600) ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
    if (hold_mode == 2) begin
      hv[3] = 1'b1;
      hv[4] = 1'b1;
    end
    // Issue decisions happen from cycle 1 on; each appears as a read one cycle later.
    k = 0;
    c = 1;
    while (k < m) begin
      if (!hv[c]) begin
        e_rd[c+1] = 1; e_rk[c+1] = k;
        e_wr[c+1+pl] = 1; e_wk[c+1+pl] = k;
        k++;
      end
      c++;
    end
    last_rd = c;
    d = last_rd + pl + 1;
    for (int i = 2; i < d; i++) e_busy[i] = 1;
    e_done[d] = 1;
    endc = d + tail;
    sel = which;
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0;
    for (int cy = 0; cy <= endc; cy++) begin
      @(posedge clk);
      #1;
      start = (cy == 0) ||
              (spam && (cy == 2 || cy == d || (cy >= 1 && cy <= d && $urandom_range(0, 2) == 0)));
      hold = hv[cy];
      @(negedge clk);
      rd_cnt += int'(o_rd_en);
      wr_cnt += int'(o_wr_en);
      done_cnt += int'(o_done);
      n_tests++;
      if (o_rd_en !== e_rd[cy]) begin
        n_fail++; $display("FAIL rd_en dut%0d cyc %0d got %0b required %0b", which, cy, o_rd_en, e_rd[cy]);
      end
      if (e_rd[cy]) begin
        n_tests++;
        if (o_rd_k !== 10'(e_rk[cy]) || o_tw1 !== 10'(e_rk[cy] % n) ||
            o_tw2 !== 10'((2 * e_rk[cy]) % n) || o_tw3 !== 10'((3 * e_rk[cy]) % n)) begin
          n_fail++;
          $display("FAIL rd_k/tw dut%0d cyc %0d got k=%0d tw=%0d,%0d,%0d required k=%0d tw=%0d,%0d,%0d",
                   which, cy, o_rd_k, o_tw1, o_tw2, o_tw3, e_rk[cy], e_rk[cy] % n,
                   (2 * e_rk[cy]) % n, (3 * e_rk[cy]) % n);
        end
      end
      n_tests++;
      if (o_wr_en !== e_wr[cy]) begin
        n_fail++; $display("FAIL wr_en dut%0d cyc %0d got %0b required %0b", which, cy, o_wr_en, e_wr[cy]);
      end
      if (e_wr[cy]) begin
        n_tests++;
        if (o_wr_k !== 10'(e_wk[cy])) begin
          n_fail++; $display("FAIL wr_k dut%0d cyc %0d got %0d required %0d", which, cy, o_wr_k, e_wk[cy]);
        end
      end
      n_tests++;
      if (o_busy !== e_busy[cy] || o_done !== e_done[cy]) begin
        n_fail++;
        $display("FAIL busy/done dut%0d cyc %0d got %0b/%0b required %0b/%0b",
                 which, cy, o_busy, o_done, e_busy[cy], e_done[cy]);
      end
    end
    start = 1'b0;
    hold = 1'b0;
    n_tests++;
    if (rd_cnt != m || wr_cnt != m || done_cnt != 1) begin
      n_fail++;
      $display("FAIL pass_counts dut%0d got rd=%0d wr=%0d done=%0d required %0d/%0d/1",
               which, rd_cnt, wr_cnt, done_cnt, m, m);
    end
  endtask

  task automatic test_basic();
    run_pass(0, 0, 1'b0, 3);
  endtask

  task automatic test_hold();
    run_pass(0, 2, 1'b0, 3);
    run_pass(0, 1, 1'b0, 3);
  endtask

  task automatic test_start_ignored();
    run_pass(0, 1, 1'b1, 3);
    run_pass(0, 0, 1'b1, 3);
  endtask

  task automatic test_reset_mid_pass();
    bit found;
    sel = 0;
    found = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_rd_en === 1'b1 && o_rd_k === 10'd2) begin
        found = 1;
        break;
      end
    end
    n_tests++;
    if (!found) begin
      n_fail++; $display("FAIL mid_reset_wait got no k=2 issue required one within 20 cycles");
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({o_rd_en, o_rd_k, o_tw1, o_tw2, o_tw3, o_wr_en, o_wr_k, o_busy, o_done} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs got %h required 0",
               {o_rd_en, o_rd_k, o_tw1, o_tw2, o_tw3, o_wr_en, o_wr_k, o_busy, o_done});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_tests++;
      if (o_done !== 1'b0 || o_wr_en !== 1'b0 || o_busy !== 1'b0 || o_rd_en !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset_quiet cyc %0d got done=%0b wr=%0b busy=%0b rd=%0b required 0",
                 i, o_done, o_wr_en, o_busy, o_rd_en);
      end
    end
    run_pass(0, 0, 1'b0, 3);
  endtask

  task automatic test_large();
    run_pass(1, 0, 1'b0, 3);
    run_pass(1, 1, 1'b1, 3);
  endtask

  task automatic test_back_to_back();
    run_pass(0, 0, 1'b0, 0);
    run_pass(0, 0, 1'b0, 0);
    run_pass(1, 0, 1'b0, 0);
    run_pass(1, 0, 1'b0, 3);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_start_ignored();
    test_reset_mid_pass();
    test_large();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
